// File: rtl/interrupt_ctrl.sv
// interrupt_ctrl: selects RESET/NMI/IRQ at opcode fetch and holds the forced-BRK
// service state until the sequencer has fetched the vector.
module interrupt_ctrl (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clk_en,
    input  logic        i_sync,
    input  logic        i_nmi_n,
    input  logic        i_irq_n,
    input  logic        i_irq_mask,
    input  logic        i_vector_done,
    output logic        o_force_brk,
    output logic [1:0]  o_int_type,
    output logic [15:0] o_vector,
    output logic        o_suppress_write
);
    typedef enum logic {IDLE, SERVICE} state_t;
    state_t      state, state_nx;
    logic        reset_pending, reset_pending_nx;
    logic        nmi_latch, nmi_latch_nx;
    logic        nmi_prev, irq_req, nmi_edge;
    logic [1:0]  int_type_nx;
    logic [15:0] vector_nx;
    always_comb begin
        state_nx         = state;
        reset_pending_nx = reset_pending;
        nmi_latch_nx     = nmi_latch;
        int_type_nx      = o_int_type;
        vector_nx        = o_vector;
        nmi_edge         = nmi_prev & ~i_nmi_n;
        if (state == IDLE && i_sync && (reset_pending || nmi_latch || irq_req)) begin
            state_nx         = SERVICE;
            int_type_nx      = reset_pending ? 2'b11 : nmi_latch ? 2'b10 : 2'b01;
            vector_nx        = reset_pending ? 16'hFFFC : nmi_latch ? 16'hFFFA : 16'hFFFE;
            reset_pending_nx = 1'b0;
            // NMI stays latched when RESET outranked it
            nmi_latch_nx     = reset_pending & nmi_latch;
        end else if (state == SERVICE && i_vector_done) begin
            state_nx    = IDLE;
            int_type_nx = 2'b00;
            vector_nx   = 16'hFFFE;
        end
        if (nmi_edge)
            nmi_latch_nx = 1'b1;
    end
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state         <= IDLE;
            reset_pending <= 1'b1;
            nmi_latch     <= 1'b0;
            nmi_prev      <= 1'b1;
            irq_req       <= 1'b0;
            o_int_type    <= 2'b00;
            o_vector      <= 16'hFFFC;
        end else if (i_clk_en) begin
            state         <= state_nx;
            reset_pending <= reset_pending_nx;
            nmi_latch     <= nmi_latch_nx;
            nmi_prev      <= i_nmi_n;
            irq_req       <= ~i_irq_n & ~i_irq_mask;
            o_int_type    <= int_type_nx;
            o_vector      <= vector_nx;
        end
    end
    assign o_force_brk      = (state == SERVICE);
    assign o_suppress_write = (state == SERVICE) && (o_int_type == 2'b11);
endmodule

// File: doc/interrupt_ctrl.md
INTERRUPT_CTRL -- requirements
Module: interrupt_ctrl

Interface
REQ-001 SHALL have `i_clk`, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have `i_reset`, input, 1 bit: synchronous, active-high reset; overrides `i_clk_en`.
REQ-003 SHALL have `i_clk_en`, input, 1 bit: state advances only on cycles where it is high.
REQ-004 SHALL have `i_sync`, input, 1 bit: high while the timing counter is at 0 (opcode fetch cycle).
REQ-005 SHALL have `i_nmi_n`, input, 1 bit: NMI pin, active-low, falling-edge triggered.
REQ-006 SHALL have `i_irq_n`, input, 1 bit: IRQ pin, active-low, level triggered.
REQ-007 SHALL have `i_irq_mask`, input, 1 bit: processor I flag; 1 blocks IRQ.
REQ-008 SHALL have `i_vector_done`, input, 1 bit: one-cycle pulse from the sequencer when the vector high byte has been fetched.
REQ-009 SHALL have `o_force_brk`, output, 1 bit: the fetched opcode is replaced by $00 and PC increment is suppressed.
REQ-010 SHALL have `o_int_type`, output, 2 bits: 00 none/BRK, 01 IRQ, 10 NMI, 11 RESET.
REQ-011 SHALL have `o_vector`, output, 16 bits: low-byte address of the active vector.
REQ-012 SHALL have `o_suppress_write`, output, 1 bit: stack pushes become reads (RESET service only).

Function
REQ-013 SHALL implement a two-state FSM, IDLE and SERVICE; all transitions occur only on `i_clk_en` cycles.
REQ-014 SHALL sample `i_nmi_n` into `nmi_prev` on every enabled cycle; prev=1 and current=0 SHALL set `nmi_latch`.
REQ-015 SHALL register `irq_req` = !`i_irq_n` AND !`i_irq_mask` on every enabled cycle; there is no IRQ latching beyond this single register.
REQ-016 In IDLE with `i_sync`=1, the FSM SHALL select by priority: RESET (`reset_pending`), then NMI (`nmi_latch`), then IRQ (`irq_req`).
  - If a source is selected: go to SERVICE and latch `o_int_type` and `o_vector` on that edge.
  - If nothing is pending: stay in IDLE.
REQ-017 Vector values SHALL be: RESET 16'hFFFC; NMI 16'hFFFA; IRQ 16'hFFFE; BRK (IDLE) 16'hFFFE.
REQ-018 Entering SERVICE for NMI SHALL clear `nmi_latch`.
  - If a new falling edge is detected on the same cycle, the set SHALL win.
REQ-019 Entering SERVICE for RESET SHALL clear `reset_pending`.
REQ-020 `o_force_brk` SHALL be high exactly while the FSM is in SERVICE, i.e. from the cycle after the selecting sync edge until `i_vector_done`.
REQ-021 `o_suppress_write` SHALL be high exactly while in SERVICE with type 11.
REQ-022 `i_vector_done` with `i_clk_en` in SERVICE SHALL return the FSM to IDLE.
  - On that edge, `o_int_type` SHALL go to 00 and `o_vector` to 16'hFFFE.
  - `i_vector_done` in IDLE SHALL be ignored.
REQ-023 `i_sync` while in SERVICE SHALL be ignored; no re-selection occurs.
REQ-024 An NMI edge arriving during IRQ service SHALL NOT alter the current vector.
  - It SHALL remain latched and be serviced at the next sync after return to IDLE.
REQ-025 An IRQ deasserted before a sync edge SHALL NOT be serviced.
REQ-026 With `i_clk_en`=0, all registers SHALL hold, and NMI edges SHALL be detected only across enabled samples.

Reset
REQ-027 `i_reset`=1 at a rising edge SHALL force:
  - FSM to IDLE, `reset_pending`=1, `nmi_latch`=0, `nmi_prev`=1, `irq_req`=0.
  - `o_force_brk`=0, `o_int_type`=00, `o_vector`=16'hFFFC, `o_suppress_write`=0.
REQ-028 Reset asserted mid-SERVICE SHALL abandon the service; the abandoned source is not retained, except that NMI edges recur only on new falling edges.
REQ-029 The first enabled sync after reset release SHALL start RESET service, regardless of NMI or IRQ.

Verification
REQ-030 Bench SHALL cover the following directed scenarios:
  - Reset, then `i_sync` pulse → next cycle `o_force_brk`=1, `o_int_type`=11, `o_vector`=FFFC, `o_suppress_write`=1; `i_vector_done` → next cycle all 0 and `o_vector`=FFFE.
  - `i_nmi_n` 1→0 held low, two syncs with `i_vector_done` between → exactly one NMI service (type 10, FFFA); second sync yields no service.
  - `i_irq_n`=0, `i_irq_mask`=1 at sync → no service; then mask=0, next sync → type 01, FFFE, `o_suppress_write`=0.
  - IRQ and NMI both pending at sync → NMI first; after done, next sync → IRQ.
  - NMI edge during IRQ SERVICE → `o_vector` stays FFFE; following sync → NMI service.
  - `i_clk_en`=0 with sync and pending NMI → no change; `i_reset`=1 mid-SERVICE → outputs at reset values next cycle.
